// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
//
// Purpose:
//   Instruction memory for the IF stage.
//   - Stores cells little-endian and serves word fetches with a one-cycle
//     registered read behind a valid/ready handshake.
//   - A word-wide, byte-enabled load port writes program images at run time.
//   - After every reset, a hardware sweep clears the array one word per cycle
//     and places BOOT_WORD at word 0.
//
// Optional feature:
//   `IMEM_MISALIGN_ERR_EN` - when defined, a fetch with fetch_addr[1:0] != 0
//   still returns the aligned word, but with rsp_err = 1. When undefined, the
//   low address bits are ignored and rsp_err reports only out-of-range.
//
// Ports:
//   clk, reset        single rising-edge clock; synchronous active-high reset
//   fetch_valid/ready fetch request handshake; fetch_addr is a byte address
//   rsp_valid/ready   response handshake; response held until consumed
//   rsp_instr         fetched word (0 when out of range)
//   rsp_addr          word-aligned address of the response
//   rsp_err           out-of-range (or misaligned, see above)
//   load_valid/ready  write handshake; load_addr low 2 bits ignored
//   load_data/load_be write word and per-cell byte enables
//   busy              init sweep in progress
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int                    WORDLENGTH = 32,
  parameter int                    CELLSIZE   = 8,
  parameter int                    DEPTH      = 1024,
  parameter logic [WORDLENGTH-1:0] BOOT_WORD  = 32'h0800_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [WORDLENGTH-1:0] fetch_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORDLENGTH-1:0] rsp_instr,
  output logic [WORDLENGTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WORDLENGTH-1:0] load_addr,
  input  logic [WORDLENGTH-1:0] load_data,
  input  logic [3:0]            load_be,
  output logic                  busy
);

  localparam int AW     = $clog2(DEPTH);  // byte address bits inside the array
  localparam int IW     = AW - 2;         // word index bits
  localparam int NWORDS = DEPTH / 4;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;
  logic          init_we;

  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rsp_inr_q;
  logic [WORDLENGTH-1:0] rsp_addr_q;
  logic [WORDLENGTH-1:0] rd_word;

  logic          fetch_fire;
  logic          load_fire;
  logic          fetch_inr;
  logic          load_inr;
  logic          fetch_mis;
  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] load_idx;

  // Low address bits of the load port never matter, and those of the fetch
  // port only matter when misalignment reporting is compiled in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[1:0], load_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    busy        = 1'b0;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    init_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
        if (sweep_q == IW'(NWORDS - 1)) begin
          state_d = ST_RUN;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_RUN: begin
        load_ready = 1'b1;
        // Load wins over fetch, so a read and a write never share a cycle.
        // fetch_valid deliberately plays no part here.
        fetch_ready = !load_valid && (!rsp_valid_q || rsp_ready);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign fetch_fire = fetch_valid && fetch_ready;
  assign load_fire  = load_valid && load_ready;
  assign fetch_inr  = (fetch_addr[WORDLENGTH-1:AW] == '0);
  assign load_inr   = (load_addr[WORDLENGTH-1:AW] == '0);
  assign fetch_idx  = fetch_addr[AW-1:2];
  assign load_idx   = load_addr[AW-1:2];

`ifdef IMEM_MISALIGN_ERR_EN
  assign fetch_mis = (fetch_addr[1:0] != 2'b00);
`else
  assign fetch_mis = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_inr_q   <= 1'b0;
      rsp_addr_q  <= '0;
    end else if (fetch_fire) begin
      // Also covers the back-to-back case: the old response is consumed this
      // cycle and replaced by the new one without a bubble.
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !fetch_inr || fetch_mis;
      rsp_inr_q   <= fetch_inr;
      rsp_addr_q  <= {fetch_addr[WORDLENGTH-1:2], 2'b00};
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one cell-wide array per byte lane, each with a registered read.
  // The read register only updates on an accepted fetch, so the response data
  // stays stable while the consumer stalls, even if loads hit the same word.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [CELLSIZE-1:0] mem [NWORDS];
      logic [CELLSIZE-1:0] rd_q;
      logic                lane_we;
      logic [IW-1:0]       lane_addr;
      logic [CELLSIZE-1:0] lane_wdata;

      // Writes are suppressed on a reset edge so a load that coincides with
      // reset never lands in the array.
      assign lane_we = !reset &&
                       (init_we || (load_fire && load_inr && load_be[gi]));
      assign lane_addr  = init_we ? sweep_q : load_idx;
      assign lane_wdata = init_we
                        ? ((sweep_q == '0) ? BOOT_WORD[gi*CELLSIZE +: CELLSIZE]
                                           : '0)
                        : load_data[gi*CELLSIZE +: CELLSIZE];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[lane_addr] <= lane_wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (fetch_fire) begin
          rd_q <= mem[fetch_idx];
        end
      end

      assign rd_word[gi*CELLSIZE +: CELLSIZE] = rd_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_addr  = rsp_addr_q;
  // The raw read data is gated so that out-of-range fetches return 0, and so
  // that the output is 0 after reset, before any read has happened.
  assign rsp_instr = (rsp_valid_q && rsp_inr_q) ? rd_word : '0;

endmodule
